// File: rtl/cpu_clk_pkg.sv
// Shared encodings for the CPU clock/step controller: mode values, FSM states, default divide.
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10
  } mode_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN_HI  = 3'd1,
    RUN_LO  = 3'd2,
    STEP_HI = 3'd3,
    STEP_LO = 3'd4
  } clk_state_t;

  localparam int DIV_DEFAULT = 10_000_000;

  function automatic logic is_high(input clk_state_t s);
    return (s == RUN_HI) || (s == STEP_HI);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer plus a debounce counter that needs
// 2^DBNC_W equal samples before the stable level follows; pulses on each stable rise.
module btn_debounce #(
  parameter int DBNC_W = 20
) (
  input  logic CLK,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic pulse
);

  logic              sync1_reg;
  logic              sync2_reg;
  logic              level_reg;
  logic              pulse_reg;
  logic [DBNC_W-1:0] cnt_reg;
  logic              differs;
  logic              settled;

  // Any return to the stable level clears the counter, so bounces restart the wait.
  assign differs = (sync2_reg != level_reg);
  assign settled = differs && (cnt_reg == {DBNC_W{1'b1}});

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      pulse_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      if (differs)
        cnt_reg <= cnt_reg + 1'b1;
      else
        cnt_reg <= '0;
      if (settled)
        level_reg <= sync2_reg;
      pulse_reg <= settled && sync2_reg;
    end
  end

  assign level = level_reg;
  assign pulse = pulse_reg;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock/step controller: free run with programmable half-period, halt, and
// debounced single-step. Optional cycle_count output under CPU_CLK_CTRL_CYCCNT_EN.
module cpu_clk_ctrl #(
  parameter int DIV_W       = 26,
  parameter int DIV_DEFAULT = cpu_clk_pkg::DIV_DEFAULT,
  parameter int DBNC_W      = 20
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             div_load,
  input  logic             step_btn,
  input  logic             halt_req,
  output logic             clk_out,
  output logic             ce,
  output logic             running
`ifdef CPU_CLK_CTRL_CYCCNT_EN
  ,
  output logic [31:0]      cycle_count
`endif
);

  import cpu_clk_pkg::*;

  localparam logic [DIV_W-1:0] RATIO_INIT = DIV_W'(DIV_DEFAULT);

  clk_state_t       state_reg;
  clk_state_t       state_next;
  logic [DIV_W-1:0] count_reg;
  logic [DIV_W-1:0] ratio_reg;
  logic [DIV_W-1:0] active_reg;
  logic             clk_out_reg;
  logic             clk_out_next;
  logic             ce_reg;
  logic             ce_next;
  logic             running_reg;
  logic             running_next;
  logic             tc;
  logic             btn_level;
  logic             step_pulse;
  logic             step_go;

  btn_debounce #(
    .DBNC_W (DBNC_W)
  ) u_step_dbnc (
    .CLK   (CLK),
    .rst   (rst),
    .btn   (step_btn),
    .level (btn_level),
    .pulse (step_pulse)
  );

  assign step_go = step_pulse && btn_level;

  // ">=" rather than "==" so a count left above the terminal value still wraps.
  assign tc = (state_reg != IDLE) && (count_reg >= active_reg);

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      clk_out_reg <= 1'b0;
      ce_reg      <= 1'b0;
      running_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clk_out_reg <= clk_out_next;
      ce_reg      <= ce_next;
      running_reg <= running_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (mode == MODE_RUN && !halt_req)
          state_next = RUN_HI;
        else if (mode == MODE_STEP && step_go)
          state_next = STEP_HI;
      end
      RUN_HI:  if (tc) state_next = RUN_LO;
      // Mode and halt are only sampled here, so no half-period is ever cut short.
      RUN_LO:  if (tc) state_next = (mode == MODE_RUN && !halt_req) ? RUN_HI : IDLE;
      STEP_HI: if (tc) state_next = STEP_LO;
      STEP_LO: if (tc) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    clk_out_next = is_high(state_next);
    ce_next      = is_high(state_next) && !is_high(state_reg);
    running_next = (state_next != IDLE);
  end

  // The active terminal count only changes at a half-period boundary or while idle.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      count_reg  <= '0;
      ratio_reg  <= RATIO_INIT;
      active_reg <= RATIO_INIT;
    end else begin
      if (div_load)
        ratio_reg <= div_ratio;
      if (state_reg == IDLE || tc) begin
        count_reg  <= '0;
        active_reg <= ratio_reg;
      end else begin
        count_reg  <= count_reg + 1'b1;
      end
    end
  end

`ifdef CPU_CLK_CTRL_CYCCNT_EN
  logic [31:0] cycle_count_reg;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst)
      cycle_count_reg <= 32'd0;
    else if (ce_next)
      cycle_count_reg <= cycle_count_reg + 32'd1;
  end

  assign cycle_count = cycle_count_reg;
`endif

  assign clk_out = clk_out_reg;
  assign ce      = ce_reg;
  assign running = running_reg;

endmodule
